// File: rtl/onehot_addr_sequencer.sv
// One-hot write-address sequencer for the CNN register banks: up/down ring or one-shot stepping,
// random-position load, binary index, wrap pulse, pass counter and self-recovery from corrupted state.
module onehot_addr_sequencer #(
    parameter int unsigned WIDTH     = 15,
    parameter int unsigned RESET_POS = 14,
    parameter int unsigned ONE_SHOT  = 0,
    parameter int unsigned PASS_W    = 8,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [IDX_W-1:0]  load_idx,
    output logic [WIDTH-1:0]  count,
    output logic [IDX_W-1:0]  idx,
    output logic              wrap,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              err
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(WIDTH - 2);
    localparam logic [IDX_W-1:0] RST_IDX   = IDX_W'(RESET_POS);
    localparam logic [WIDTH-1:0] RST_VEC   = WIDTH'(1) << RESET_POS;

    logic [WIDTH-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [PASS_W-1:0] pass_q, pass_d;

    logic              onehot_ok_c;
    logic              load_ok_c;
    logic              at_top_c;
    logic              at_bot_c;
    logic              at_term_c;
    logic              lands_term_c;
    logic [IDX_W-1:0]  step_idx_c;

    // count is trusted only if exactly one bit is set; anything else triggers recovery
    assign onehot_ok_c = (count_q != '0) && ((count_q & (count_q - WIDTH'(1))) == '0);
    assign load_ok_c   = 32'(load_idx) < WIDTH;
    assign at_top_c    = (idx_q == LAST_IDX);
    assign at_bot_c    = (idx_q == '0);
    assign at_term_c   = dir ? at_bot_c : at_top_c;

    // Position after a non-wrapping step, and whether that step lands on the terminal position
    assign step_idx_c   = dir ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    assign lands_term_c = dir ? (idx_q == IDX_W'(1)) : (idx_q == PRE_LAST);

    // Next-state selection in priority order: recovery, clr, load, step, hold
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        done_d = done_q;
        pass_d = pass_q;

        if (!onehot_ok_c) begin
            idx_d  = RST_IDX;
            err_d  = 1'b1;
            done_d = 1'b0;
        end else if (clr) begin
            idx_d  = RST_IDX;
            pass_d = '0;
            done_d = 1'b0;
        end else if (load) begin
            if (load_ok_c) begin
                idx_d  = load_idx;
                done_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            if (ONE_SHOT != 0) begin
                // A step past the terminal position is swallowed entirely
                if (!at_term_c) begin
                    idx_d  = step_idx_c;
                    done_d = lands_term_c;
                    if (lands_term_c) begin
                        pass_d = pass_q + PASS_W'(1);
                    end
                end
            end else begin
                if (at_term_c) begin
                    idx_d  = dir ? LAST_IDX : '0;
                    wrap_d = 1'b1;
                    pass_d = pass_q + PASS_W'(1);
                end else begin
                    idx_d = step_idx_c;
                end
            end
        end
    end

    assign count_d = WIDTH'(1) << idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VEC;
            idx_q   <= RST_IDX;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pass_q  <= '0;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign count    = count_q;
    assign idx      = idx_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign err      = err_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_onehot_addr_sequencer.sv
// Scoreboard bench: three sequencer configurations (ring default, one-shot 8-wide, ring with 2-bit
// pass counter) driven side by side against a behavioural reference model.
module tb_onehot_addr_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       clr  [3];
    logic       en   [3];
    logic       dir  [3];
    logic       load [3];
    logic [3:0] lidx [3];

    logic [14:0] a_count, c_count;
    logic [7:0]  b_count;
    logic [3:0]  a_idx, c_idx;
    logic [2:0]  b_idx;
    logic [7:0]  a_pass, b_pass;
    logic [1:0]  c_pass;
    logic        a_wrap, a_done, a_err, b_wrap, b_done, b_err, c_wrap, c_done, c_err;

    onehot_addr_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .en(en[0]), .dir(dir[0]), .load(load[0]),
        .load_idx(lidx[0]), .count(a_count), .idx(a_idx), .wrap(a_wrap), .done(a_done),
        .pass_cnt(a_pass), .err(a_err)
    );

    onehot_addr_sequencer #(.WIDTH(8), .RESET_POS(0), .ONE_SHOT(1), .PASS_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .en(en[1]), .dir(dir[1]), .load(load[1]),
        .load_idx(lidx[1][2:0]), .count(b_count), .idx(b_idx), .wrap(b_wrap), .done(b_done),
        .pass_cnt(b_pass), .err(b_err)
    );

    onehot_addr_sequencer #(.WIDTH(15), .RESET_POS(14), .ONE_SHOT(0), .PASS_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]), .en(en[2]), .dir(dir[2]), .load(load[2]),
        .load_idx(lidx[2]), .count(c_count), .idx(c_idx), .wrap(c_wrap), .done(c_done),
        .pass_cnt(c_pass), .err(c_err)
    );

    logic [14:0] cnt_o  [3];
    logic [3:0]  idx_o  [3];
    logic [7:0]  pass_o [3];
    logic        wrap_o [3];
    logic        done_o [3];
    logic        err_o  [3];

    always_comb begin
        cnt_o[0]  = a_count;       cnt_o[1]  = 15'(b_count);  cnt_o[2]  = c_count;
        idx_o[0]  = a_idx;         idx_o[1]  = 4'(b_idx);     idx_o[2]  = c_idx;
        pass_o[0] = a_pass;        pass_o[1] = b_pass;        pass_o[2] = 8'(c_pass);
        wrap_o[0] = a_wrap;        wrap_o[1] = b_wrap;        wrap_o[2] = c_wrap;
        done_o[0] = a_done;        done_o[1] = b_done;        done_o[2] = c_done;
        err_o[0]  = a_err;         err_o[1]  = b_err;         err_o[2]  = c_err;
    end

    int p_w  [3] = '{15, 8, 15};
    int p_rp [3] = '{14, 0, 14};
    int p_os [3] = '{0, 1, 0};
    int p_pm [3] = '{256, 256, 4};

    int m_pos  [3];
    int m_pass [3];
    bit m_done [3];

    typedef struct {
        int k;
        int cnt;
        int idx;
        bit wrap;
        bit done;
        bit err;
        int pass;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string phase = "init";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0; en[k] = 1'b0; dir[k] = 1'b0; load[k] = 1'b0; lidx[k] = 4'd0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pos[k] = p_rp[k]; m_pass[k] = 0; m_done[k] = 1'b0;
        end
    endtask

    // Reference model of one clock edge for configuration k; pushes the expected outputs
    task automatic model_step(input int k, input bit fault);
        exp_t e;
        int   w;
        int   li;
        int   nxt;
        bit   wrapped;
        bit   wr;
        bit   er;
        w  = p_w[k];
        wr = 1'b0;
        er = 1'b0;
        li = (k == 1) ? int'(lidx[k][2:0]) : int'(lidx[k]);
        if (fault) begin
            m_pos[k] = p_rp[k]; m_done[k] = 1'b0; er = 1'b1;
        end else if (clr[k]) begin
            m_pos[k] = p_rp[k]; m_pass[k] = 0; m_done[k] = 1'b0;
        end else if (load[k]) begin
            if (li < w) begin
                m_pos[k] = li; m_done[k] = 1'b0;
            end else begin
                er = 1'b1;
            end
        end else if (en[k]) begin
            nxt     = dir[k] ? (m_pos[k] + w - 1) % w : (m_pos[k] + 1) % w;
            wrapped = dir[k] ? (m_pos[k] == 0) : (m_pos[k] == w - 1);
            if (p_os[k] != 0) begin
                if (!wrapped) begin
                    m_pos[k] = nxt;
                    if (nxt == (dir[k] ? 0 : w - 1)) begin
                        m_done[k] = 1'b1; m_pass[k]++;
                    end else begin
                        m_done[k] = 1'b0;
                    end
                end
            end else begin
                m_pos[k] = nxt;
                if (wrapped) begin
                    wr = 1'b1; m_pass[k]++;
                end
            end
        end
        m_pass[k] = m_pass[k] % p_pm[k];
        e.k = k; e.cnt = 1 << m_pos[k]; e.idx = m_pos[k];
        e.wrap = wr; e.done = m_done[k]; e.err = er; e.pass = m_pass[k];
        sb.push_back(e);
    endtask

    // Called with inputs already applied after a falling edge; compares right after the next rising edge
    task automatic step(input int fault_k = -1);
        exp_t e;
        for (int k = 0; k < 3; k++) model_step(k, k == fault_k);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s[%0d].count", phase, e.k), 32'(cnt_o[e.k]),  e.cnt);
            chk($sformatf("%s[%0d].idx",   phase, e.k), 32'(idx_o[e.k]),  e.idx);
            chk($sformatf("%s[%0d].wrap",  phase, e.k), 32'(wrap_o[e.k]), 32'(e.wrap));
            chk($sformatf("%s[%0d].done",  phase, e.k), 32'(done_o[e.k]), 32'(e.done));
            chk($sformatf("%s[%0d].err",   phase, e.k), 32'(err_o[e.k]),  32'(e.err));
            chk($sformatf("%s[%0d].pass",  phase, e.k), 32'(pass_o[e.k]), e.pass);
        end
    endtask

    task automatic chk_reset();
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s[%0d].rst_count", phase, k), 32'(cnt_o[k]),  1 << p_rp[k]);
            chk($sformatf("%s[%0d].rst_idx",   phase, k), 32'(idx_o[k]),  p_rp[k]);
            chk($sformatf("%s[%0d].rst_wrap",  phase, k), 32'(wrap_o[k]), 0);
            chk($sformatf("%s[%0d].rst_done",  phase, k), 32'(done_o[k]), 0);
            chk($sformatf("%s[%0d].rst_err",   phase, k), 32'(err_o[k]),  0);
            chk($sformatf("%s[%0d].rst_pass",  phase, k), 32'(pass_o[k]), 0);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        phase = "reset";
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // T1: ring up from reset, 16 steps
        phase = "t1";
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); en[0] = 1'b1; dir[0] = 1'b0;
            step();
        end
        chk("t1.count_after16", 32'(a_count), 32'h0001);
        chk("t1.pass_after16",  32'(a_pass),  2);

        // T2: ring down from the reset position, then reverse mid-run
        phase = "t2";
        @(negedge clk); idle(); clr[0] = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); idle(); en[0] = 1'b1; dir[0] = 1'b1;
            step();
        end
        chk("t2.wrap_down",  32'(a_wrap),  1);
        chk("t2.count_down", 32'(a_count), 32'h4000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); en[0] = 1'b1; dir[0] = 1'b1;
            step();
        end
        @(negedge clk); en[0] = 1'b1; dir[0] = 1'b0;
        step();
        chk("t2.dir_flip", 32'(a_count), 32'h1000);
        @(negedge clk); en[0] = 1'b1; dir[0] = 1'b0;
        step();

        // T3: load, bad load, load beats en, clr beats load
        phase = "t3";
        @(negedge clk); idle(); load[0] = 1'b1; lidx[0] = 4'd5;
        step();
        chk("t3.load5_count", 32'(a_count), 32'h0020);
        chk("t3.load5_idx",   32'(a_idx),   5);
        @(negedge clk); lidx[0] = 4'd15;
        step();
        chk("t3.badload_err",   32'(a_err),   1);
        chk("t3.badload_count", 32'(a_count), 32'h0020);
        @(negedge clk); lidx[0] = 4'd3; en[0] = 1'b1;
        step();
        chk("t3.load_over_en", 32'(a_count), 32'h0008);
        @(negedge clk); clr[0] = 1'b1; lidx[0] = 4'd7;
        step();
        chk("t3.clr_count", 32'(a_count), 32'h4000);
        chk("t3.clr_pass",  32'(a_pass),  0);

        // T4: one-shot 8-wide instance
        phase = "t4";
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); idle(); en[1] = 1'b1; dir[1] = 1'b0;
            step();
        end
        chk("t4.end_count", 32'(b_count), 32'h80);
        chk("t4.end_done",  32'(b_done),  1);
        chk("t4.end_pass",  32'(b_pass),  1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); en[1] = 1'b1;
            step();
        end
        chk("t4.blocked_count", 32'(b_count), 32'h80);
        chk("t4.blocked_wrap",  32'(b_wrap),  0);
        @(negedge clk); en[1] = 1'b1; dir[1] = 1'b1;
        step();
        chk("t4.back_count", 32'(b_count), 32'h40);
        chk("t4.back_done",  32'(b_done),  0);

        // T5: corrupted state recovery, then asynchronous reset mid-sweep
        phase = "t5";
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); en[0] = 1'b1;
            step();
        end
        @(negedge clk);
        force dut_a.count_q = 15'h0003;
        en[0] = 1'b1;
        #1;
        release dut_a.count_q;
        step(0);
        chk("t5.recover_count", 32'(a_count), 32'h4000);
        chk("t5.recover_err",   32'(a_err),   1);
        @(negedge clk); idle();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b1;
            step();
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        phase = "t5_async";
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        phase = "t5_after";
        @(negedge clk); en[0] = 1'b1;
        step();

        // T6: 2-bit pass counter rolls over after four wraps
        phase = "t6";
        for (int i = 0; i < 46; i++) begin
            @(negedge clk); idle(); en[2] = 1'b1;
            step();
        end
        chk("t6.pass_rollover", 32'(c_pass),  0);
        chk("t6.count",         32'(c_count), 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
